// File: rtl/framebuffer_fill_if.sv
// Purpose: command and frame-memory write bus of the rectangle fill engine.
// Latency: none, signal bundle only.
// Backpressure: cmd_valid/cmd_ready handshake; the memory write port is never stalled.
// Ports: cmd_* carry one rectangle or clear command with its 12-bit colour;
//        mem_we/mem_addr/mem_data form the single-pixel write port to frame memory.
interface framebuffer_fill_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_clear;
    logic [7:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [7:0]  cmd_w;
    logic [6:0]  cmd_h;
    logic [11:0] cmd_color;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [11:0] mem_data;

    // Command source / memory sink side.
    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, mem_we, mem_addr, mem_data
    );

    // Fill engine side.
    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/framebuffer_fill.sv
// Purpose: fills a clipped rectangle (or the whole frame) with one colour, one pixel per cycle.
// Latency: first write the cycle after acceptance; done one cycle after the last write.
// Backpressure: cmd_ready only in IDLE, commands are not queued; the write port never stalls.
// Ports: clk, reset (sync, active-high); bus (framebuffer_fill_if.slave) carries the
//        command handshake and the memory write port; busy is high in FILL/FINISH;
//        done is a one-cycle pulse when a command completes.
module framebuffer_fill #(
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic                clk,
    input  logic                reset,
    framebuffer_fill_if.slave   bus,
    output logic                busy,
    output logic                done
);

    localparam logic [8:0]  H_LIM    = 9'(H_RES);
    localparam logic [8:0]  V_LIM    = 9'(V_RES);
    localparam logic [16:0] ROW_STEP = 17'(H_RES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Coordinates are carried 9 bits wide so that x+w and y+h never overflow.
    logic [8:0]  x_start_q, x_end_q, y_end_q;
    logic [8:0]  x_cnt_q, y_cnt_q;
    logic [16:0] row_base_q;
    logic [11:0] color_q;

    logic        accept;
    logic        acc_empty;
    logic [8:0]  x_sum, y_sum;
    logic [8:0]  acc_x_start, acc_y_start, acc_x_end, acc_y_end;
    logic [16:0] acc_row_base;
    logic        mem_we;

    // Bounds for the command on the input pins. The clear flag is folded into
    // these bounds here, so it needs no register of its own.
    always_comb begin
        x_sum       = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
        y_sum       = {2'b0, bus.cmd_y} + {2'b0, bus.cmd_h};
        acc_x_start = '0;
        acc_y_start = '0;
        acc_x_end   = H_LIM - 9'd1;
        acc_y_end   = V_LIM - 9'd1;
        acc_empty   = 1'b0;
        if (!bus.cmd_clear) begin
            acc_x_start = {1'b0, bus.cmd_x};
            acc_y_start = {2'b0, bus.cmd_y};
            acc_x_end   = ((x_sum > H_LIM) ? H_LIM : x_sum) - 9'd1;
            acc_y_end   = ((y_sum > V_LIM) ? V_LIM : y_sum) - 9'd1;
            // An empty command's end bounds may wrap; they are never used.
            acc_empty   = (bus.cmd_w == 8'd0) || (bus.cmd_h == 7'd0) ||
                          (acc_x_start >= H_LIM) || (acc_y_start >= V_LIM);
        end
        // The only multiply sits at acceptance; per-pixel addressing is add-only.
        acc_row_base = 17'(acc_y_start) * ROW_STEP;
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.cmd_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        mem_we        = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = acc_empty ? FINISH : FILL;
                end
            end
            FILL: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                if ((x_cnt_q == x_end_q) && (y_cnt_q == y_end_q)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_start_q  <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            row_base_q <= '0;
            color_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_start_q  <= acc_x_start;
                x_cnt_q    <= acc_x_start;
                x_end_q    <= acc_x_end;
                y_cnt_q    <= acc_y_start;
                y_end_q    <= acc_y_end;
                row_base_q <= acc_row_base;
                color_q    <= bus.cmd_color;
            end else if (state_q == FILL) begin
                // The step past the final pixel is harmless: FINISH gates mem_we off.
                if (x_cnt_q == x_end_q) begin
                    x_cnt_q    <= x_start_q;
                    y_cnt_q    <= y_cnt_q + 9'd1;
                    row_base_q <= row_base_q + ROW_STEP;
                end else begin
                    x_cnt_q <= x_cnt_q + 9'd1;
                end
            end
        end
    end

    // Address and data are forced to zero whenever no write is issued.
    assign bus.mem_we   = mem_we;
    assign bus.mem_addr = mem_we ? (row_base_q + 17'(x_cnt_q)) : 17'd0;
    assign bus.mem_data = mem_we ? color_q : 12'd0;

endmodule

// File: tb/tb_framebuffer_fill.sv
module tb_framebuffer_fill;
    localparam int H = 160;
    localparam int V = 120;

    logic clk = 1'b0;
    logic reset;
    logic busy, done;
    int   checks = 0;
    int   errors = 0;

    framebuffer_fill_if bus();

    framebuffer_fill #(.H_RES(H), .V_RES(V)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observation of one command, filled by exec_cmd.
    int          obs_addr[$];
    logic [11:0] obs_data[$];
    int          exp_addr[$];
    int          done_cyc, idle_bad, busy_bad, acc_ok, ready_after;

    // Reference: every pixel of the clipped rectangle in raster order.
    task automatic build_model(input bit clr, input int x, input int y, input int w, input int h);
        int xe, ye;
        exp_addr.delete();
        if (clr) begin x = 0; y = 0; w = H; h = V; end
        xe = (x + w < H) ? x + w : H;
        ye = (y + h < V) ? y + h : V;
        for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++)
                exp_addr.push_back(yy * H + xx);
    endtask

    task automatic scramble();
        bus.cmd_clear = 1'($urandom);
        bus.cmd_x     = 8'($urandom);
        bus.cmd_y     = 7'($urandom);
        bus.cmd_w     = 8'($urandom);
        bus.cmd_h     = 7'($urandom);
        bus.cmd_color = 12'($urandom);
    endtask

    // Drives one command and records what the DUT writes. Cycle 1 is the
    // first cycle after acceptance.
    task automatic exec_cmd(input bit clr, input int x, input int y, input int w, input int h,
                            input logic [11:0] col, input int limit);
        obs_addr.delete(); obs_data.delete();
        done_cyc = -1; idle_bad = 0; busy_bad = 0; acc_ok = 0; ready_after = 0;
        @(negedge clk);
        bus.cmd_clear = clr; bus.cmd_x = x[7:0]; bus.cmd_y = y[6:0];
        bus.cmd_w = w[7:0]; bus.cmd_h = h[6:0]; bus.cmd_color = col;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        acc_ok = 1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        scramble();
        for (int c = 1; c <= limit; c++) begin
            if (!busy) busy_bad++;
            if (bus.mem_we) begin
                obs_addr.push_back(int'(bus.mem_addr));
                obs_data.push_back(bus.mem_data);
            end else if (bus.mem_addr !== 17'd0 || bus.mem_data !== 12'd0) begin
                idle_bad++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        if (done_cyc > 0) begin
            @(negedge clk);
            ready_after = int'(bus.cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.mem_addr); end
        checks++; if (bus.mem_data !== 12'd0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.mem_data); end
        reset = 1'b0;
    endtask

    // Directed rectangles: plain, clipped corner, full-width row, single pixel.
    task automatic test_rect_table();
        int tx[4] = '{10, 158, 0, 159};
        int ty[4] = '{5, 118, 60, 119};
        int tw[4] = '{3, 10, 200, 1};
        int th[4] = '{2, 10, 1, 1};
        int want0[2][6] = '{'{810, 811, 812, 970, 971, 972}, '{19038, 19039, 19198, 19199, 0, 0}};
        int want_n[2] = '{6, 4};
        for (int t = 0; t < 4; t++) begin
            logic [11:0] col;
            col = 12'($urandom);
            build_model(1'b0, tx[t], ty[t], tw[t], th[t]);
            exec_cmd(1'b0, tx[t], ty[t], tw[t], th[t], col, 400);
            checks++; if (acc_ok !== 1) begin errors++; $display("FAIL rect%0d_accept: got %0d want 1", t, acc_ok); end
            if (t < 2) begin
                checks++; if (obs_addr.size() !== want_n[t]) begin errors++; $display("FAIL rect%0d_count: got %0d want %0d", t, obs_addr.size(), want_n[t]); end
                for (int i = 0; i < want_n[t] && i < obs_addr.size(); i++) begin
                    checks++; if (obs_addr[i] !== want0[t][i]) begin errors++; $display("FAIL rect%0d_addr%0d: got %0d want %0d", t, i, obs_addr[i], want0[t][i]); end
                end
            end
            checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL rect%0d_model_count: got %0d want %0d", t, obs_addr.size(), exp_addr.size()); end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== col) begin errors++; $display("FAIL rect%0d_pix%0d: got %0d/%h want %0d/%h", t, i, obs_addr[i], obs_data[i], exp_addr[i], col); end
            end
            checks++; if (done_cyc !== exp_addr.size() + 1) begin errors++; $display("FAIL rect%0d_done_cycle: got %0d want %0d", t, done_cyc, exp_addr.size() + 1); end
            checks++; if (idle_bad !== 0 || busy_bad !== 0) begin errors++; $display("FAIL rect%0d_idle_busy: got %0d/%0d want 0/0", t, idle_bad, busy_bad); end
            checks++; if (ready_after !== 1) begin errors++; $display("FAIL rect%0d_ready_after: got %0d want 1", t, ready_after); end
        end
    endtask

    // Empty commands: no writes, done in the first cycle after acceptance.
    task automatic test_empty();
        int tx[5] = '{10, 200, 20, 5, 0};
        int ty[5] = '{10, 10, 20, 120, 127};
        int tw[5] = '{0, 5, 4, 3, 50};
        int th[5] = '{4, 4, 0, 5, 5};
        for (int t = 0; t < 5; t++) begin
            exec_cmd(1'b0, tx[t], ty[t], tw[t], th[t], 12'hABC, 50);
            checks++; if (acc_ok !== 1) begin errors++; $display("FAIL empty%0d_accept: got %0d want 1", t, acc_ok); end
            checks++; if (obs_addr.size() !== 0) begin errors++; $display("FAIL empty%0d_writes: got %0d want 0", t, obs_addr.size()); end
            checks++; if (done_cyc !== 1) begin errors++; $display("FAIL empty%0d_done_cycle: got %0d want 1", t, done_cyc); end
            checks++; if (ready_after !== 1) begin errors++; $display("FAIL empty%0d_ready_after: got %0d want 1", t, ready_after); end
            checks++; if (idle_bad !== 0 || busy_bad !== 0) begin errors++; $display("FAIL empty%0d_idle_busy: got %0d/%0d want 0/0", t, idle_bad, busy_bad); end
        end
    endtask

    task automatic test_clear();
        int bad = 0;
        exec_cmd(1'b1, 77, 33, 5, 5, 12'hF00, H * V + 20);
        checks++; if (acc_ok !== 1) begin errors++; $display("FAIL clear_accept: got %0d want 1", acc_ok); end
        checks++; if (obs_addr.size() !== H * V) begin errors++; $display("FAIL clear_count: got %0d want %0d", obs_addr.size(), H * V); end
        for (int i = 0; i < obs_addr.size() && bad < 5; i++) begin
            checks++;
            if (obs_addr[i] !== i || obs_data[i] !== 12'hF00) begin
                errors++; bad++;
                $display("FAIL clear_pix%0d: got %0d/%h want %0d/f00", i, obs_addr[i], obs_data[i], i);
            end
        end
        checks++; if (done_cyc !== H * V + 1) begin errors++; $display("FAIL clear_done_cycle: got %0d want %0d", done_cyc, H * V + 1); end
        checks++; if (idle_bad !== 0 || busy_bad !== 0) begin errors++; $display("FAIL clear_idle_busy: got %0d/%0d want 0/0", idle_bad, busy_bad); end
    endtask

    task automatic test_reset_mid();
        int nw = 0, stray = 0;
        @(negedge clk);
        bus.cmd_clear = 1'b1; bus.cmd_color = 12'h0F0; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (bus.mem_we) nw++;
            if (nw == 100) begin reset = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (nw !== 100) begin errors++; $display("FAIL rstmid_reach100: got %0d want 100", nw); end
        @(negedge clk);
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_state: got ready=%b busy=%b done=%b want 1/0/0", bus.cmd_ready, busy, done); end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_we || done) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_stray: got %0d want 0", stray); end
    endtask

    task automatic test_reset_priority();
        int stray = 0;
        @(negedge clk);
        bus.cmd_clear = 1'b0; bus.cmd_x = 8'd4; bus.cmd_y = 7'd4; bus.cmd_w = 8'd4; bus.cmd_h = 7'd4;
        bus.cmd_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        repeat (10) begin
            if (bus.mem_we || done || busy || !bus.cmd_ready) stray++;
            @(negedge clk);
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rstprio_dropped: got %0d want 0", stray); end
    endtask

    // Second command held valid throughout the first one's fill.
    task automatic test_back_to_back();
        int bx, by, bw, bh, na, acc_cyc = -1, dones = 0, done2 = -1, rdy_bad = 0;
        int seq[$];
        bx = $urandom_range(0, 150); by = $urandom_range(0, 110);
        bw = $urandom_range(1, 8);   bh = $urandom_range(1, 4);
        build_model(1'b0, 10, 5, 3, 2);
        seq = exp_addr;
        na = exp_addr.size();
        build_model(1'b0, bx, by, bw, bh);
        seq = {seq, exp_addr};
        obs_addr.delete();
        @(negedge clk);
        bus.cmd_clear = 1'b0; bus.cmd_x = 8'd10; bus.cmd_y = 7'd5; bus.cmd_w = 8'd3; bus.cmd_h = 7'd2;
        bus.cmd_color = 12'h123; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
        @(negedge clk);
        bus.cmd_x = bx[7:0]; bus.cmd_y = by[6:0]; bus.cmd_w = bw[7:0]; bus.cmd_h = bh[6:0];
        for (int c = 1; c < 200 && dones < 2; c++) begin
            if (bus.cmd_ready === busy) rdy_bad++;
            if (bus.mem_we) obs_addr.push_back(int'(bus.mem_addr));
            if (done) begin dones++; if (dones == 2) done2 = c; end
            if (bus.cmd_ready && bus.cmd_valid && acc_cyc < 0) begin
                acc_cyc = c;
                @(negedge clk);
                bus.cmd_valid = 1'b0;
                scramble();
                continue;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checks++; if (acc_cyc !== na + 2) begin errors++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_cyc, na + 2); end
        checks++; if (obs_addr !== seq) begin errors++; $display("FAIL b2b_sequence: got %0d writes want %0d", obs_addr.size(), seq.size()); end
        checks++; if (done2 !== seq.size() + 3) begin errors++; $display("FAIL b2b_done2_cycle: got %0d want %0d", done2, seq.size() + 3); end
        checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL b2b_ready_vs_busy: got %0d want 0", rdy_bad); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int x, y, w, h;
            logic [11:0] col;
            x = $urandom_range(0, 170); y = $urandom_range(0, 127);
            w = $urandom_range(0, 40);  h = $urandom_range(0, 16);
            col = 12'($urandom);
            build_model(1'b0, x, y, w, h);
            exec_cmd(1'b0, x, y, w, h, col, 1000);
            checks++; if (acc_ok !== 1 || obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d (x=%0d y=%0d w=%0d h=%0d)", t, obs_addr.size(), exp_addr.size(), x, y, w, h); end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== col) begin errors++; $display("FAIL rand%0d_pix%0d: got %0d/%h want %0d/%h", t, i, obs_addr[i], obs_data[i], exp_addr[i], col); end
            end
            checks++; if (done_cyc !== exp_addr.size() + 1) begin errors++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", t, done_cyc, exp_addr.size() + 1); end
            checks++; if (idle_bad !== 0 || busy_bad !== 0 || ready_after !== 1) begin errors++; $display("FAIL rand%0d_idle_busy_ready: got %0d/%0d/%0d want 0/0/1", t, idle_bad, busy_bad, ready_after); end
        end
    endtask

    initial begin
        test_reset();
        test_rect_table();
        test_empty();
        test_clear();
        test_reset_mid();
        test_reset_priority();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
